// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo drain slice: FSM state encoding and
// default sizing constants that match the upstream fifo instances.
package fifo_pkg;

    // Drain FSM: pick a channel, wait for the fifo output register, hold for the consumer.
    typedef enum logic [1:0] {
        ARB  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int NUM_CH_DEF     = 4;
    localparam int DATA_WIDTH_DEF = 16;  // must track the upstream fifo word width
    localparam int CNT_WIDTH_DEF  = 16;

endpackage : fifo_pkg

// File: rtl/fifo_rr_drain_if.sv
// Bundle between the per-channel fifos, the drain block and the output consumer.
// master = the drain block, slave = fifos plus consumer (the environment).
interface fifo_rr_drain_if
    import fifo_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int CH_IDX_W   = $clog2(NUM_CH)
);

    logic [NUM_CH-1:0]            ch_empty;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_pop;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CH_IDX_W-1:0]          out_ch;
    logic                         out_valid;
    logic                         out_ready;
    logic [CNT_WIDTH-1:0]         word_cnt;

    modport master (
        input  ch_empty, ch_data, out_ready,
        output ch_pop, out_data, out_ch, out_valid, word_cnt
    );

    modport slave (
        output ch_empty, ch_data, out_ready,
        input  ch_pop, out_data, out_ch, out_valid, word_cnt
    );

endinterface : fifo_rr_drain_if

// File: rtl/fifo_rr_drain_rr_arbiter.sv
// Combinational round-robin pick: the first requester found scanning upward
// from ptr (wrapping) wins. No state; the caller owns the pointer.
module rr_arbiter #(
    parameter int NUM_CH   = 4,
    parameter int CH_IDX_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0]   req,
    input  logic [CH_IDX_W-1:0] ptr,
    output logic [NUM_CH-1:0]   grant,
    output logic [CH_IDX_W-1:0] grant_idx,
    output logic                any_req
);

    logic [CH_IDX_W-1:0] cand;

    // Scan ptr, ptr+1, ... with natural index wrap; keep the first hit only.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves
        // a value unassigned and no latch is inferred. Blocking assignments are
        // required here: later iterations must see any_req set by earlier ones.
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        cand      = ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = ptr + CH_IDX_W'(i);
            if (!any_req && req[cand]) begin
                any_req         = 1'b1;
                grant_idx       = cand;
                grant[cand]     = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NUM_CH fifos onto one valid/ready port. Pops one
// word from a non-empty fifo, captures it from the fifo output register a
// cycle later, then holds it until the consumer takes it.
module fifo_rr_drain
    import fifo_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int CH_IDX_W   = $clog2(NUM_CH),
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    fifo_rr_drain_if.master bus
);

    localparam logic [CH_IDX_W-1:0]  IDX_ONE = CH_IDX_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e                  state_q,     state_d;
    logic [CH_IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [CH_IDX_W-1:0]     grant_q,     grant_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic [CH_IDX_W-1:0]     out_ch_q,    out_ch_d;
    logic                    out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]    word_cnt_q,  word_cnt_d;

    logic [NUM_CH-1:0]       arb_grant;
    logic [CH_IDX_W-1:0]     arb_idx;
    logic                    arb_any;
    logic [DATA_WIDTH-1:0]   sel_word;

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .CH_IDX_W (CH_IDX_W)
    ) u_arb (
        .req       (~bus.ch_empty),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    // Pop strobe only while arbitrating, and never during reset or flush.
    assign bus.ch_pop = (rst_n && !i_flush && (state_q == ARB)) ? arb_grant : '0;

    // Select the granted fifo's output word (valid in the cycle after its pop).
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == CH_IDX_W'(i)) begin
                sel_word = bus.ch_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic: flush overrides the FSM, rr_ptr and word_cnt are kept.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        word_cnt_d  = word_cnt_q;

        if (i_flush) begin
            state_d     = ARB;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ARB: begin
                    if (arb_any) begin
                        grant_d  = arb_idx;
                        rr_ptr_d = arb_idx + IDX_ONE;  // served channel drops to lowest priority
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    out_data_d  = sel_word;
                    out_ch_d    = grant_q;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_d = 1'b0;
                        word_cnt_d  = word_cnt_q + CNT_ONE;
                        state_d     = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of statement order.
        if (!rst_n) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
    assign bus.word_cnt  = word_cnt_q;

endmodule : fifo_rr_drain

// File: doc/fifo_rr_drain.md
Name: fifo_rr_drain

Overview:
Downstream consumer of NUM_CH fifo instances. Arbitrates round-robin among non-empty channels and issues a one-cycle pop to the granted fifo. Captures that fifo's registered output one cycle later and presents it on a valid/ready output port, together with the source channel index. Sits between the per-channel fifos and the shared output mux/datapath.

Parameters:
NUM_CH, 4, number of upstream fifo channels (power of two, ≥2)
CH_IDX_W, 2, log2(NUM_CH); width of channel index
DATA_WIDTH, 16, word width; must equal the upstream fifo width
CNT_WIDTH, 16, width of the transferred-word counter

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
i_flush  in  1  synchronous abort; drops any in-flight word
ch_empty  in  NUM_CH  per-channel fifo empty flag, bit i = channel i
ch_data  in  NUM_CH*DATA_WIDTH  flattened fifo outputs, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
ch_pop  out  NUM_CH  one-hot pop strobe to fifos
out_data  out  DATA_WIDTH  captured word
out_ch  out  CH_IDX_W  source channel of out_data
out_valid  out  1  out_data/out_ch valid
out_ready  in  1  consumer accepts when out_valid & out_ready
word_cnt  out  CNT_WIDTH  count of words accepted at output, wraps

Behaviour:
- Reset (rst_n=0 at posedge): state=ARB, rr_ptr=0, out_valid=0, out_data=0, out_ch=0, word_cnt=0, grant register=0. ch_pop is combinational and is 0 while in reset.
- FSM states: ARB, WAIT, HOLD.
- ARB:
  - Search channels rr_ptr, rr_ptr+1, … mod NUM_CH.
  - First channel g with ch_empty[g]=0 is granted.
  - ch_pop[g]=1 for this cycle only (combinational from state and ch_empty).
  - Register g; set rr_ptr <= (g+1) mod NUM_CH; go to WAIT.
  - If all channels are empty: ch_pop=0, stay in ARB, rr_ptr unchanged.
- WAIT:
  - ch_pop=0. The fifo has updated its output at the pop edge, so ch_data[g] is valid this cycle.
  - At the edge: out_data <= ch_data[g], out_ch <= g, out_valid <= 1; go to HOLD.
- HOLD:
  - ch_pop=0. out_data and out_ch are held stable while out_valid=1.
  - On out_valid & out_ready: out_valid <= 0, word_cnt <= word_cnt+1 (wraps modulo 2^CNT_WIDTH), go to ARB.
  - Otherwise stay in HOLD. Backpressure is unbounded.
- Latency: pop cycle → out_valid asserted 2 edges later. Maximum throughput is 1 word per 3 cycles.
- Fairness: a channel that was just served has the lowest priority on the next arbitration. With all channels non-empty, grants follow 0,1,2,3,0,…
- Index arithmetic is CH_IDX_W bits, natural wrap.
- ch_pop is never asserted to an empty channel, is never multi-hot, and is never asserted outside ARB.
- i_flush: priority below reset, above everything else.
  - At the edge: state <= ARB, out_valid <= 0, ch_pop forced 0 in that cycle, rr_ptr unchanged, word_cnt unchanged.
  - A word popped but not yet accepted is discarded.
- i_flush and out_ready in the same HOLD cycle: flush wins, word_cnt does not increment.
- Reset mid-operation: identical to power-on reset. Any pending word is lost.
- ch_empty changing during WAIT/HOLD is ignored; it is sampled only in ARB.

Decomposition:
- Shared package fifo_pkg:
  - state typedef enum {ARB, WAIT, HOLD}
  - DATA_WIDTH default constant, matching the fifo width
- One sub-module, rr_arbiter:
  - Purely combinational round-robin priority pick.
  - Inputs: req (=~ch_empty), ptr.
  - Outputs: one-hot grant, grant index, any_req.
  - Reusable elsewhere.
- Top module holds the FSM, rr_ptr, capture registers and counter.

Test Plan:
- Single channel: ch_empty=4'b1011, ch_data[2] becomes 16'hA5A5 after the pop edge, out_ready=1 → ch_pop=4'b0100 for one cycle, 2 edges later out_valid=1, out_data=16'hA5A5, out_ch=2, word_cnt 0→1.
- Round-robin: all channels non-empty, out_ready=1, 8 transfers → out_ch sequence 0,1,2,3,0,1,2,3; word_cnt=8; pop strobes 3 cycles apart.
- Skip and wrap: rr_ptr=3, ch_empty=4'b1110 → grant 0, rr_ptr becomes 1. Then ch_empty=4'b0111 → grant 3, rr_ptr becomes 0.
- Backpressure: out_ready=0 for 10 cycles in HOLD → out_valid stays 1, out_data/out_ch stable, no ch_pop. Raise out_ready → one accept, word_cnt+1, ARB on the next cycle.
- Flush in WAIT and in HOLD (with out_ready=1 in the same cycle) → out_valid=0 next cycle, word_cnt unchanged, state=ARB, rr_ptr retains its post-grant value.
- Reset mid-HOLD with out_valid=1 → next cycle out_valid=0, word_cnt=0, rr_ptr=0, no ch_pop during reset.
